// File: rtl/data_mem_ctrl.sv
// Byte-addressed data memory for the load/store stage: byte/half/word access,
// sign/zero-extended loads, req/done handshake with LAT cycles of latency.
module data_mem_ctrl #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32,
    parameter int LAT    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              err
);
    localparam int IW = $clog2(DEPTH);

    if (LAT < 1 || LAT > 15) begin : g_lat_chk
        $fatal(1, "data_mem_ctrl: LAT must be in 1..15");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    typedef struct packed {
        logic          we;
        logic [1:0]    size;
        logic          uns;
        logic [1:0]    lane;
        logic [IW-1:0] idx;
        logic          fault;
    } req_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    req_t        cur, req_in;
    logic [31:0] rdata_q, rword, ld_val, wd;
    logic        err_q;
    logic        accept, fault_in, misalign, oor, wr_en;
    logic [3:0]  be;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;

    // Fault is decided on the incoming request so a faulting store never touches memory.
    assign misalign = (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
    assign oor      = |(addr >> (IW + 2));
    assign fault_in = (size == 2'b11) || misalign || oor;
    assign accept   = ready & req;
    assign wr_en    = accept & we & ~fault_in;
    assign req_in   = '{we: we, size: size, uns: uns, lane: addr[1:0],
                        idx: addr[IW+1:2], fault: fault_in};

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: if (req) begin
                state_nxt = BUSY;
                cnt_nxt   = 4'(LAT - 1);
            end
            BUSY: if (cnt == 4'd0) state_nxt = DONE;
                  else             cnt_nxt   = cnt - 4'd1;
            DONE: if (req) begin
                state_nxt = BUSY;
                cnt_nxt   = 4'(LAT - 1);
            end else begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            cur     <= '0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) cur <= req_in;
            if (state == BUSY && cnt == 4'd0) begin
                err_q   <= cur.fault;
                rdata_q <= (cur.fault || cur.we) ? 32'd0 : ld_val;
            end
        end
    end

    assign ready = (state != BUSY);
    assign done  = (state == DONE);
    assign err   = done & err_q;
    assign rdata = rdata_q;

    // Store data is replicated across lanes; the byte enables pick which lanes land.
    always_comb begin
        be = 4'b0000;
        wd = wdata;
        case (size)
            2'b00: begin be = 4'b0001 << addr[1:0]; wd = {4{wdata[7:0]}};  end
            2'b01: begin be = 4'b0011 << addr[1:0]; wd = {2{wdata[15:0]}}; end
            2'b10: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    for (genvar b = 0; b < 4; b++) begin : g_lane
        logic [7:0] mem [DEPTH];
        always_ff @(posedge clk) begin
            if (wr_en && be[b]) mem[addr[IW+1:2]] <= wd[8*b +: 8];
        end
        assign rword[8*b +: 8] = mem[cur.idx];
    end

    assign ld_b = rword[{cur.lane, 3'b000} +: 8];
    assign ld_h = cur.lane[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        case (cur.size)
            2'b00:   ld_val = {{24{~cur.uns & ld_b[7]}}, ld_b};
            2'b01:   ld_val = {{16{~cur.uns & ld_h[15]}}, ld_h};
            default: ld_val = rword;
        endcase
    end
endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Parametrised, byte-addressed synchronous data memory for the CPU load/store stage.
- Supports byte, half-word and word access, with sign or zero extension on loads.
- Request/done handshake with a configurable access latency; one access outstanding at a time.
- Reports misaligned, out-of-range or reserved-size accesses on an error flag.

Parameters:
- DEPTH, 256, number of 32-bit words; power of two, at least 4
- ADDR_W, 32, width of the byte address
- LAT, 1, cycles from acceptance to done; range 1..15

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  1  access request; sampled only while ready=1
- we  input  1  1 = store, 0 = load
- size  input  2  00 byte, 01 half, 10 word, 11 reserved
- uns  input  1  loads only: 1 = zero-extend, 0 = sign-extend
- addr  input  ADDR_W  byte address
- wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
- ready  output  1  block idle, can accept a request
- done  output  1  one-cycle completion pulse
- rdata  output  32  load result; valid while done=1
- err  output  1  access faulted; valid while done=1

Behaviour:
- Reset (asynchronous, rst_n=0): ready=1, done=0, rdata=0, err=0, state IDLE, latency counter=0.
  - Memory contents are not cleared and are undefined after reset.
- States:
  - IDLE: ready=1. If req=1 at a rising edge, latch we/size/uns/addr/wdata, go to BUSY, counter=LAT-1.
  - BUSY: ready=0, done=0. Each edge: if counter=0, go to DONE; else decrement.
  - DONE (one cycle): done=1, ready=1; rdata and err hold the result. The next edge returns to IDLE.
    - If req=1 at that edge, the new request is accepted and the state goes straight to BUSY.
- Timing: a request accepted at edge T0 gives done high in the cycle after edge T0+LAT. Maximum throughput is one access per LAT+1 cycles.
- req while ready=0 is ignored; no queuing.
- Address decode: word index = addr[log2(DEPTH)+1:2], lane = addr[1:0].
- Fault conditions (checked on the latched request):
  - size=11
  - size=01 and addr[0]=1
  - size=10 and addr[1:0]!=00
  - addr >= 4*DEPTH
- On a fault: memory is not modified, rdata=0, err=1 in the DONE cycle; latency is unchanged.
- Store (no fault): memory is written at the acceptance edge.
  - Byte: wdata[7:0] to lane byte `lane`.
  - Half: wdata[15:0] to bytes {lane+1, lane}.
  - Word: wdata to the whole word.
  - Other bytes in the word are preserved (byte-enable write). In DONE, rdata=0 and err=0.
- Load (no fault): the word is read at the edge entering DONE.
  - Byte: selected byte; bits [31:8] = 0 if uns, else copies of bit 7.
  - Half: selected half; bits [31:16] = 0 if uns, else copies of bit 15.
  - Word: full word. uns is ignored.
- Outside DONE, done=0 and err=0; rdata holds its last value.
- Byte order is little-endian: lane 0 = bits [7:0].
- Reset during BUSY aborts the access: no done pulse is produced.
  - A store accepted before the reset is already committed and is not rolled back.
- LAT outside 1..15 is a configuration error; the simulation check issues $fatal at time 0.

Test Plan:
- Reset, then word store 0xDEADBEEF to addr 0x10, then word load from 0x10 (LAT=1) -> done two cycles after each acceptance; rdata=0xDEADBEEF, err=0; ready low exactly one cycle per access.
- After the above, byte store 0x5A to 0x12, then word load 0x10 -> 0xDE5ABEEF. Byte load 0x13 signed -> 0xFFFFFFDE; unsigned -> 0x000000DE.
- Half store 0x8001 to 0x20 (word previously 0), then half load 0x20 signed -> 0xFFFF8001; unsigned -> 0x00008001; word load 0x20 -> 0x00008001.
- Faults: half load at 0x21, word store at 0x22, size=11, load at addr 4*DEPTH -> each gives err=1, rdata=0; a following word load of the targeted word shows it unchanged.
- LAT=3, req held high continuously -> done every 4th cycle; req during BUSY is ignored; the request present in the DONE cycle is accepted back-to-back.
- rst_n pulled low during BUSY of a load -> no done pulse; ready=1 immediately. A store accepted before the reset remains visible to a later load.
